// File: rtl/fft_bank_sched.sv
// ---------------------------------------------------------------------------
// fft_bank_sched
//   Ping-pong bank scheduler that sits between an FFT core and a display.
//   The FFT writes whole frames into one bank while the display reads
//   passes out of the other. The banks swap only between display passes,
//   so a pass never sees a half-written frame.
//
//   Optional macro: FFT_BANK_STATS_EN
//     defined   -> drop_cnt / short_cnt are saturating 8-bit event counters
//     undefined -> both counters are tied to 0 and no counter logic exists
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   fft_valid     : FFT output sample valid
//   fft_eop       : last sample of an FFT frame (qualified by fft_valid)
//   wr_en         : write strobe to the bank RAM
//   wr_bank       : bank being written
//   wr_addr       : write address within wr_bank
//   frame_start   : display requests a new pass (one-cycle pulse)
//   rd_req        : display consumes one point
//   rd_bank       : bank being read (always ~wr_bank)
//   rd_addr       : read address within rd_bank
//   rd_active     : a display pass is in progress
//   point_done    : pulse, last point of the pass was consumed
//   bank_valid    : rd_bank holds a complete frame
//   drop_cnt      : frames dropped because no bank was free
//   short_cnt     : frames discarded for an early fft_eop
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module fft_bank_sched #(
  parameter int TRANSFORM_LEN = 1024,
  parameter int DISP_LEN      = TRANSFORM_LEN / 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    fft_valid,
  input  logic                                    fft_eop,
  output logic                                    wr_en,
  output logic                                    wr_bank,
  output logic [$clog2(TRANSFORM_LEN)-1:0]        wr_addr,
  input  logic                                    frame_start,
  input  logic                                    rd_req,
  output logic                                    rd_bank,
  output logic [$clog2(DISP_LEN)-1:0]             rd_addr,
  output logic                                    rd_active,
  output logic                                    point_done,
  output logic                                    bank_valid,
  output logic [7:0]                              drop_cnt,
  output logic [7:0]                              short_cnt
);

  localparam int AW = $clog2(TRANSFORM_LEN);
  localparam int RW = $clog2(DISP_LEN);
  localparam logic [AW-1:0] W_LAST = AW'(TRANSFORM_LEN - 1);
  localparam logic [RW-1:0] R_LAST = RW'(DISP_LEN - 1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_HOLD} wstate_t;
  typedef enum logic       {R_IDLE, R_DRAW}         rstate_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  wstate_t         r_ws, w_ws_nxt;
  rstate_t         r_rs, w_rs_nxt;

  logic            r_wr_en,      w_wr_en_nxt;
  logic            r_wr_bank,    w_wr_bank_nxt;
  logic [AW-1:0]   r_wr_addr,    w_wr_addr_nxt;
  logic [AW-1:0]   r_cnt,        w_cnt_nxt;     // index of the next sample
  logic            r_full,       w_full_nxt;    // all TRANSFORM_LEN slots written
  logic            r_ready,      w_ready_nxt;   // complete frame waiting to swap
  logic            r_bank_valid, w_bank_valid_nxt;
  logic            r_rd_bank;
  logic [RW-1:0]   r_rd_addr,    w_rd_addr_nxt;
  logic            r_rd_active;
  logic            r_point_done, w_point_done_nxt;

  // ---------------------------------------------------------------------
  // Write-side event decode
  // ---------------------------------------------------------------------
  logic            w_in_frame;
  logic            w_full_c;
  logic [AW-1:0]   w_idx;
  logic            w_evt_write;
  logic            w_evt_complete;
  logic            w_evt_short;
  logic            w_swap;

  always_comb begin
    w_in_frame     = (r_ws != W_HOLD);
    // A fresh frame always starts at slot 0, whatever the counter holds.
    w_idx          = (r_ws == W_IDLE) ? '0 : r_cnt;
    w_full_c       = (r_ws == W_FILL) && r_full;
    w_evt_write    = w_in_frame && fft_valid && !w_full_c;
    w_evt_complete = w_in_frame && fft_valid && fft_eop &&
                     (w_full_c || (w_idx == W_LAST));
    w_evt_short    = w_in_frame && fft_valid && fft_eop &&
                     !w_full_c && (w_idx != W_LAST);
    // ready is only ever set in W_HOLD, so a swap always leaves W_HOLD.
    w_swap         = r_ready && !r_rd_active;
  end

  // ---------------------------------------------------------------------
  // Write FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ws <= W_IDLE;
    else     r_ws <= w_ws_nxt;
  end

  always_comb begin
    w_ws_nxt = r_ws;
    if (w_swap) begin
      w_ws_nxt = W_IDLE;
    end else begin
      unique case (r_ws)
        W_IDLE: begin
          if (w_evt_complete)                 w_ws_nxt = W_HOLD;
          else if (fft_valid && !w_evt_short) w_ws_nxt = W_FILL;
        end
        W_FILL: begin
          if (w_evt_complete)   w_ws_nxt = W_HOLD;
          else if (w_evt_short) w_ws_nxt = W_IDLE;
        end
        W_HOLD:  w_ws_nxt = W_HOLD;
        default: w_ws_nxt = W_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wr_en_nxt      = 1'b0;
    w_wr_addr_nxt    = r_wr_addr;   // held while overflowing or holding
    w_cnt_nxt        = r_cnt;
    w_full_nxt       = r_full;
    w_ready_nxt      = r_ready;
    w_wr_bank_nxt    = r_wr_bank;
    w_bank_valid_nxt = r_bank_valid;

    if (w_evt_write) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_addr_nxt = w_idx;
      if (!fft_eop) begin
        if (w_idx == W_LAST) w_full_nxt = 1'b1;
        else                 w_cnt_nxt  = w_idx + AW'(1);
      end
    end

    if (w_evt_complete) begin
      w_ready_nxt = 1'b1;
      w_cnt_nxt   = '0;
      w_full_nxt  = 1'b0;
    end

    // Early eop: the frame is abandoned. The strobe for the eop sample
    // lands on slot 0, which the next frame overwrites first anyway.
    if (w_evt_short) begin
      w_wr_addr_nxt = '0;
      w_cnt_nxt     = '0;
      w_full_nxt    = 1'b0;
    end

    if (w_swap) begin
      w_wr_bank_nxt    = ~r_wr_bank;
      w_ready_nxt      = 1'b0;
      w_bank_valid_nxt = 1'b1;
      w_wr_addr_nxt    = '0;
      w_cnt_nxt        = '0;
      w_full_nxt       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en      <= 1'b0;
      r_wr_bank    <= 1'b0;
      r_wr_addr    <= '0;
      r_cnt        <= '0;
      r_full       <= 1'b0;
      r_ready      <= 1'b0;
      r_bank_valid <= 1'b0;
      r_rd_bank    <= 1'b1;
    end else begin
      r_wr_en      <= w_wr_en_nxt;
      r_wr_bank    <= w_wr_bank_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_full       <= w_full_nxt;
      r_ready      <= w_ready_nxt;
      r_bank_valid <= w_bank_valid_nxt;
      r_rd_bank    <= ~w_wr_bank_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Read FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  logic w_rd_last;
  assign w_rd_last = (r_rd_addr == R_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rs <= R_IDLE;
    else     r_rs <= w_rs_nxt;
  end

  always_comb begin
    w_rs_nxt = r_rs;
    unique case (r_rs)
      R_IDLE:  if (frame_start)          w_rs_nxt = R_DRAW;
      R_DRAW:  if (rd_req && w_rd_last)  w_rs_nxt = R_IDLE;
      default: w_rs_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_addr_nxt    = r_rd_addr;
    w_point_done_nxt = 1'b0;
    if (r_rs == R_IDLE) begin
      if (frame_start) w_rd_addr_nxt = '0;
    end else if (rd_req) begin
      if (w_rd_last) begin
        w_rd_addr_nxt    = '0;
        w_point_done_nxt = 1'b1;
      end else begin
        w_rd_addr_nxt = r_rd_addr + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr    <= '0;
      r_rd_active  <= 1'b0;
      r_point_done <= 1'b0;
    end else begin
      r_rd_addr    <= w_rd_addr_nxt;
      r_rd_active  <= (w_rs_nxt == R_DRAW);
      r_point_done <= w_point_done_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------
`ifdef FFT_BANK_STATS_EN
  logic       w_evt_drop;
  logic [7:0] r_drop_cnt;
  logic [7:0] r_short_cnt;

  // Any frame end seen while a finished frame still waits is lost.
  assign w_evt_drop = (r_ws == W_HOLD) && fft_valid && fft_eop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt  <= '0;
      r_short_cnt <= '0;
    end else begin
      if (w_evt_drop  && (r_drop_cnt  != 8'hFF)) r_drop_cnt  <= r_drop_cnt  + 8'd1;
      if (w_evt_short && (r_short_cnt != 8'hFF)) r_short_cnt <= r_short_cnt + 8'd1;
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign short_cnt = r_short_cnt;
`else
  assign drop_cnt  = 8'd0;
  assign short_cnt = 8'd0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign wr_en      = r_wr_en;
  assign wr_bank    = r_wr_bank;
  assign wr_addr    = r_wr_addr;
  assign rd_bank    = r_rd_bank;
  assign rd_addr    = r_rd_addr;
  assign rd_active  = r_rd_active;
  assign point_done = r_point_done;
  assign bank_valid = r_bank_valid;

endmodule

// File: tb/tb_fft_bank_sched.sv
// ---------------------------------------------------------------------------
// tb_fft_bank_sched
//   Directed bench for fft_bank_sched with default parameters
//   (1024-point frames, 512-point display passes). Counter expectations
//   follow whether FFT_BANK_STATS_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_fft_bank_sched;

`ifdef FFT_BANK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fft_valid, fft_eop, frame_start, rd_req;
  logic       wr_en, wr_bank, rd_bank, rd_active, point_done, bank_valid;
  logic [9:0] wr_addr;
  logic [8:0] rd_addr;
  logic [7:0] drop_cnt, short_cnt;

  int checks = 0;
  int errors = 0;

  fft_bank_sched dut (
    .clk        (clk),
    .rst        (rst),
    .fft_valid  (fft_valid),
    .fft_eop    (fft_eop),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .frame_start(frame_start),
    .rd_req     (rd_req),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_active  (rd_active),
    .point_done (point_done),
    .bank_valid (bank_valid),
    .drop_cnt   (drop_cnt),
    .short_cnt  (short_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr_en"},      wr_en,      0);
    chk({tag, "_wr_bank"},    wr_bank,    0);
    chk({tag, "_rd_bank"},    rd_bank,    1);
    chk({tag, "_wr_addr"},    wr_addr,    0);
    chk({tag, "_rd_addr"},    rd_addr,    0);
    chk({tag, "_rd_active"},  rd_active,  0);
    chk({tag, "_point_done"}, point_done, 0);
    chk({tag, "_bank_valid"}, bank_valid, 0);
    chk({tag, "_drop_cnt"},   drop_cnt,   0);
    chk({tag, "_short_cnt"},  short_cnt,  0);
  endtask

  // n samples, eop optionally on the last; wr=1 expects writes at base+i,
  // wr=0 expects no strobe and wr_addr held at base.
  task automatic feed(input int n, input bit eop_last, input int base, input bit wr);
    for (int i = 0; i < n; i++) begin
      fft_valid = 1'b1;
      fft_eop   = eop_last && (i == n - 1);
      tick();
      if (wr) begin
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, base + i);
      end else begin
        chk("wr_en_idle", wr_en, 0);
        chk("wr_addr_held", wr_addr, base);
      end
    end
    fft_valid = 1'b0;
    fft_eop   = 1'b0;
  endtask

  // n read requests starting from rd_addr=base; point_done only after 511.
  task automatic reqs(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      chk("rd_addr", rd_addr, base + i);
      rd_req = 1'b1;
      tick();
      chk("point_done", point_done, (base + i == 511) ? 1 : 0);
    end
    rd_req = 1'b0;
  endtask

  task automatic start_pass();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fft_valid = 1'b0; fft_eop = 1'b0; frame_start = 1'b0; rd_req = 1'b0;
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();

    // First full frame, display idle: swap the cycle after completion.
    feed(1024, 1'b1, 0, 1'b1);
    chk("pre_swap_bank", wr_bank, 0);
    chk("pre_swap_valid", bank_valid, 0);
    tick();
    chk("swap_wr_bank", wr_bank, 1);
    chk("swap_rd_bank", rd_bank, 0);
    chk("swap_valid", bank_valid, 1);
    chk("swap_wr_addr", wr_addr, 0);
    chk("swap_wr_en", wr_en, 0);

    // Full display pass.
    start_pass();
    chk("pass_active", rd_active, 1);
    reqs(512, 0);
    chk("pass_end_active", rd_active, 0);
    chk("pass_end_addr", rd_addr, 0);
    tick();
    chk("pd_single", point_done, 0);

    // Frame completes mid-pass: swap deferred, second frame dropped.
    start_pass();
    reqs(100, 0);
    chk("mid_rd_addr", rd_addr, 100);
    feed(1024, 1'b1, 0, 1'b1);
    tick();
    chk("defer_wr_bank", wr_bank, 1);
    chk("defer_wr_addr", wr_addr, 1023);
    feed(1024, 1'b1, 1023, 1'b0);
    chk("drop_one", drop_cnt, STATS ? 1 : 0);
    reqs(412, 100);
    chk("defer_at_pd", wr_bank, 1);
    tick();
    chk("late_swap_wr_bank", wr_bank, 0);
    chk("late_swap_rd_bank", rd_bank, 1);
    chk("late_swap_pd", point_done, 0);
    chk("late_swap_wr_addr", wr_addr, 0);

    // Short frame: eop on sample index 500.
    feed(500, 1'b0, 0, 1'b1);
    fft_valid = 1'b1; fft_eop = 1'b1;
    tick();
    fft_valid = 1'b0; fft_eop = 1'b0;
    chk("short_cnt", short_cnt, STATS ? 1 : 0);
    chk("short_wr_addr", wr_addr, 0);
    chk("short_wr_bank", wr_bank, 0);
    chk("short_valid", bank_valid, 1);
    tick();
    chk("short_no_swap", wr_bank, 0);
    feed(1024, 1'b1, 0, 1'b1);
    tick();
    chk("after_short_swap", wr_bank, 1);

    // Overflow past the last slot, then eop completes the frame.
    feed(1024, 1'b0, 0, 1'b1);
    feed(5, 1'b0, 1023, 1'b0);
    feed(1, 1'b1, 1023, 1'b0);
    // ready and frame_start in the same cycle.
    start_pass();
    chk("same_cyc_wr_bank", wr_bank, 0);
    chk("same_cyc_rd_bank", rd_bank, 1);
    chk("same_cyc_active", rd_active, 1);
    chk("same_cyc_rd_addr", rd_addr, 0);

    // Saturate the drop counter while the pass holds the banks.
    feed(1024, 1'b1, 0, 1'b1);
    for (int k = 0; k < 300; k++) feed(1, 1'b1, 1023, 1'b0);
    chk("drop_sat", drop_cnt, STATS ? 255 : 0);
    chk("short_keep", short_cnt, STATS ? 1 : 0);
    chk("sat_bank_stable", wr_bank, 0);
    reqs(512, 0);
    tick();
    chk("sat_swap", wr_bank, 1);

    // Asynchronous reset mid-frame and mid-pass.
    start_pass();
    reqs(200, 0);
    feed(701, 1'b0, 0, 1'b1);
    chk("pre_rst_wr_addr", wr_addr, 700);
    chk("pre_rst_rd_addr", rd_addr, 200);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    tick();
    rst = 1'b0;
    feed(1, 1'b0, 0, 1'b1);
    chk("post_rst_active", rd_active, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bank_sched.md
FFT_BANK_SCHED -- requirements
Module: fft_bank_sched

Interface
REQ-001 SHALL have parameter TRANSFORM_LEN, default 1024: points per FFT frame; a power of two.
REQ-002 SHALL have parameter DISP_LEN, default TRANSFORM_LEN/2: points read per display pass.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 fft_valid  in  1  FFT output sample valid.
REQ-007 fft_eop  in  1  last sample of an FFT frame; qualified by fft_valid.
REQ-008 wr_en  out  1  write strobe to the bank RAM.
REQ-009 wr_bank  out  1  bank currently being written.
REQ-010 wr_addr  out  log2(TRANSFORM_LEN)  write address within wr_bank.
REQ-011 frame_start  in  1  one-cycle pulse: the display requests a new pass.
REQ-012 rd_req  in  1  the display consumes one point.
REQ-013 rd_bank  out  1  bank being read; always ~wr_bank.
REQ-014 rd_addr  out  log2(DISP_LEN)  read address within rd_bank.
REQ-015 rd_active  out  1  a display pass is in progress.
REQ-016 point_done  out  1  one-cycle pulse: the last point of the pass was consumed.
REQ-017 bank_valid  out  1  rd_bank holds a complete frame.
REQ-018 drop_cnt  out  8  frames dropped because no bank was free.
REQ-019 short_cnt  out  8  frames discarded for early fft_eop.

Function
REQ-020 The write FSM SHALL have three states: W_IDLE, W_FILL and W_HOLD.
REQ-021 W_IDLE: the first fft_valid SHALL assert wr_en with wr_addr=0 and move to W_FILL; wr_addr SHALL increment on each accepted sample.
REQ-022 W_FILL: wr_en SHALL equal fft_valid.
REQ-023 In W_FILL, fft_valid&fft_eop at wr_addr=TRANSFORM_LEN-1 SHALL set ready=1 and move to W_HOLD.
REQ-024 fft_valid&fft_eop at any other wr_addr SHALL discard the frame: short_cnt+1, wr_addr=0, go to W_IDLE; ready and the banks SHALL be unchanged.
REQ-025 After wr_addr=TRANSFORM_LEN-1 with no fft_eop, further samples SHALL be ignored (wr_en=0, wr_addr held) until fft_eop, which completes the frame as in REQ-023.
REQ-026 W_HOLD: wr_en SHALL be 0; each fft_valid&fft_eop SHALL increment drop_cnt.
REQ-027 A swap SHALL occur in any cycle where ready=1 and rd_active=0.
REQ-028 On a swap: wr_bank SHALL toggle, ready=0, bank_valid=1, wr_addr=0, and the write FSM SHALL go to W_IDLE.
REQ-029 The read FSM SHALL have two states: R_IDLE and R_DRAW; rd_active=1 exactly in R_DRAW.
REQ-030 R_IDLE with frame_start SHALL enter R_DRAW with rd_addr=0.
REQ-031 R_DRAW with rd_req SHALL increment rd_addr.
REQ-032 rd_req at rd_addr=DISP_LEN-1 SHALL pulse point_done for one cycle, set rd_addr=0 and return to R_IDLE.
REQ-033 frame_start in R_DRAW SHALL be ignored; rd_req in R_IDLE SHALL be ignored.
REQ-034 A swap and frame_start in the same cycle SHALL both take effect; the new pass reads the new rd_bank.
REQ-035 A swap SHALL never occur while rd_active=1, so rd_bank is stable for a whole pass.
REQ-036 Both counters SHALL saturate at 255.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 rst SHALL immediately force: both FSMs idle, wr_en=0, wr_bank=0, wr_addr=0, rd_addr=0, rd_active=0, point_done=0, ready=0, bank_valid=0, drop_cnt=0, short_cnt=0.
REQ-039 Reset mid-frame or mid-pass SHALL abandon it; the first fft_valid after release SHALL restart at wr_addr=0.

Configuration
REQ-040 Macro FFT_BANK_STATS_EN defined: drop_cnt and short_cnt SHALL behave per REQ-024, REQ-026 and REQ-036.
REQ-041 Macro FFT_BANK_STATS_EN undefined: drop_cnt and short_cnt SHALL be constant 0, with no counter logic; all other behaviour SHALL be identical.

Verification
REQ-042 Reset, then 1024 valid samples with eop on the last -> wr_addr 0..1023, ready=1; display idle -> swap next cycle: wr_bank=1, rd_bank=0, bank_valid=1.
REQ-043 frame_start, then 512 rd_req -> rd_addr 0..511; point_done exactly once, in the cycle after the 512th request; rd_active returns to 0.
REQ-044 Frame completes mid-pass at rd_addr=100 -> no swap until the pass ends; swap in the cycle after point_done; one further complete frame during the hold -> drop_cnt=1.
REQ-045 eop at sample 500 -> short_cnt=1, wr_addr=0, banks unchanged; the next full frame completes normally.
REQ-046 ready=1 and frame_start in the same cycle -> bank toggles and the pass starts on the new rd_bank; 300 extra drops -> drop_cnt=255 (with the macro); without the macro both counters read 0.
REQ-047 rst asserted at wr_addr=700 and rd_addr=200 -> all outputs at reset values immediately, without waiting for a clock edge.
